// File: rtl/calc_share_arbiter_if.sv
// Bundle of requester, result and calculator-core signals for calc_share_arbiter.
// The slave view belongs to the arbiter; the master view belongs to the surrounding environment.
interface calc_share_arbiter_if #(
  parameter int DW  = 3,
  parameter int OPW = 3,
  parameter int RW  = 7
);
  logic           req0;
  logic           req1;
  logic [DW-1:0]  a0;
  logic [DW-1:0]  a1;
  logic [DW-1:0]  b0;
  logic [DW-1:0]  b1;
  logic [OPW-1:0] op0;
  logic [OPW-1:0] op1;
  logic           ms0;
  logic           ms1;
  logic           gnt0;
  logic           gnt1;
  logic           done0;
  logic           done1;
  logic [RW-1:0]  res0;
  logic [RW-1:0]  res1;
  logic           busy;
  logic [DW-1:0]  calc_a;
  logic [DW-1:0]  calc_b;
  logic [OPW-1:0] calc_op;
  logic           calc_ms;
  logic           calc_equal;
  logic [RW-1:0]  calc_c;

  modport slave (
    input  req0, req1, a0, a1, b0, b1, op0, op1, ms0, ms1, calc_c,
    output gnt0, gnt1, done0, done1, res0, res1, busy,
           calc_a, calc_b, calc_op, calc_ms, calc_equal
  );

  modport master (
    output req0, req1, a0, a1, b0, b1, op0, op1, ms0, ms1, calc_c,
    input  gnt0, gnt1, done0, done1, res0, res1, busy,
           calc_a, calc_b, calc_op, calc_ms, calc_equal
  );
endinterface

// File: rtl/calc_share_arbiter.sv
// Round-robin sharing of one calculator core between two requesters.
// Each transaction is issued, waited on for CALC_LAT cycles, and its result returned with a done pulse.
module calc_share_arbiter #(
  parameter int DW       = 3,
  parameter int OPW      = 3,
  parameter int RW       = 7,
  parameter int CALC_LAT = 2
) (
  input logic                  clk,
  input logic                  reset,
  calc_share_arbiter_if.slave  bus
);

  localparam int CW = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           rrPtr_q, rrPtr_d;
  logic           win_q, win_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  calcA_q, calcA_d;
  logic [DW-1:0]  calcB_q, calcB_d;
  logic [OPW-1:0] calcOp_q, calcOp_d;
  logic           calcMs_q, calcMs_d;
  logic [RW-1:0]  res0_q, res0_d;
  logic [RW-1:0]  res1_q, res1_d;
  logic           pick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rrPtr_q  <= 1'b0;
      win_q    <= 1'b0;
      cnt_q    <= '0;
      calcA_q  <= '0;
      calcB_q  <= '0;
      calcOp_q <= '0;
      calcMs_q <= 1'b0;
      res0_q   <= '0;
      res1_q   <= '0;
    end else begin
      state_q  <= state_d;
      rrPtr_q  <= rrPtr_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      calcA_q  <= calcA_d;
      calcB_q  <= calcB_d;
      calcOp_q <= calcOp_d;
      calcMs_q <= calcMs_d;
      res0_q   <= res0_d;
      res1_q   <= res1_d;
    end
  end

  // Requester inputs are only looked at in IDLE; the latched operands then stay frozen until the next grant.
  always_comb begin
    state_d  = state_q;
    rrPtr_d  = rrPtr_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    calcA_d  = calcA_q;
    calcB_d  = calcB_q;
    calcOp_d = calcOp_q;
    calcMs_d = calcMs_q;
    res0_d   = res0_q;
    res1_d   = res1_q;
    pick     = (bus.req0 && bus.req1) ? rrPtr_q : bus.req1;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          win_d    = pick;
          rrPtr_d  = ~pick;
          calcA_d  = pick ? bus.a1  : bus.a0;
          calcB_d  = pick ? bus.b1  : bus.b0;
          calcOp_d = pick ? bus.op1 : bus.op0;
          calcMs_d = pick ? bus.ms1 : bus.ms0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(CALC_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (win_q) begin
            res1_d = bus.calc_c;
          end else begin
            res0_d = bus.calc_c;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gnt0       = (state_q == ISSUE) && !win_q;
  assign bus.gnt1       = (state_q == ISSUE) &&  win_q;
  assign bus.done0      = (state_q == RESP)  && !win_q;
  assign bus.done1      = (state_q == RESP)  &&  win_q;
  assign bus.calc_equal = (state_q == ISSUE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.calc_a     = calcA_q;
  assign bus.calc_b     = calcB_q;
  assign bus.calc_op    = calcOp_q;
  assign bus.calc_ms    = calcMs_q;
  assign bus.res0       = res0_q;
  assign bus.res1       = res1_q;

  // Only one requester can ever own the core at a time.
  gntExclusive: assert property (@(posedge clk) disable iff (reset) !(bus.gnt0 && bus.gnt1));
  doneExclusive: assert property (@(posedge clk) disable iff (reset) !(bus.done0 && bus.done1));

endmodule

// File: tb/tb_calc_share_arbiter.sv
// Directed scoreboard bench for calc_share_arbiter with an add/multiply calculator stub.
module tb_calc_share_arbiter;

  localparam int DW       = 3;
  localparam int OPW      = 3;
  localparam int RW       = 7;
  localparam int CALC_LAT = 2;

  typedef struct {
    int            id;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OPW-1:0] op;
    logic          ms;
    logic [RW-1:0] res;
  } txn_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  txn_t sb[$];
  logic [RW-1:0] lastRes0;
  logic [RW-1:0] lastRes1;

  logic [RW-1:0] pipeD [CALC_LAT];
  logic          pipeV [CALC_LAT];

  calc_share_arbiter_if #(.DW(DW), .OPW(OPW), .RW(RW)) bus ();

  calc_share_arbiter #(.DW(DW), .OPW(OPW), .RW(RW), .CALC_LAT(CALC_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Calculator stub: result appears CALC_LAT cycles after the evaluate strobe, garbage otherwise.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CALC_LAT; i++) pipeV[i] <= 1'b0;
    end else begin
      pipeV[0] <= bus.calc_equal;
      pipeD[0] <= (bus.calc_op == 3'b001) ? ({4'b0, bus.calc_a} * {4'b0, bus.calc_b})
                                          : ({4'b0, bus.calc_a} + {4'b0, bus.calc_b});
      for (int i = 1; i < CALC_LAT; i++) begin
        pipeV[i] <= pipeV[i-1];
        pipeD[i] <= pipeD[i-1];
      end
    end
  end

  assign bus.calc_c = pipeV[CALC_LAT-1] ? pipeD[CALC_LAT-1] : 7'h7F;

  function automatic logic [RW-1:0] expResult(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [OPW-1:0] op);
    logic [RW-1:0] ea;
    logic [RW-1:0] eb;
    ea = RW'(a);
    eb = RW'(b);
    return (op == 3'b001) ? RW'(ea * eb) : RW'(ea + eb);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [OPW-1:0] op, input logic ms);
    txn_t t;
    if (id == 0) begin
      bus.a0 = a; bus.b0 = b; bus.op0 = op; bus.ms0 = ms; bus.req0 = 1'b1;
    end else begin
      bus.a1 = a; bus.b1 = b; bus.op1 = op; bus.ms1 = ms; bus.req1 = 1'b1;
    end
    t.id = id; t.a = a; t.b = b; t.op = op; t.ms = ms; t.res = expResult(a, b, op);
    sb.push_back(t);
  endtask

  task automatic waitGrant(output int gCyc);
    logic found;
    found = 1'b0;
    gCyc  = -1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      checkOutput("noDoneBeforeGnt", {bus.done1, bus.done0}, 2'b00);
      if (bus.gnt0 || bus.gnt1) begin
        found = 1'b1;
        gCyc  = cyc;
        checkOutput("gntId", {bus.gnt1, bus.gnt0}, (sb[0].id == 1) ? 2'b10 : 2'b01);
        checkOutput("calcEqualAtGnt", bus.calc_equal, 1'b1);
        checkOutput("calcOperands", {bus.calc_a, bus.calc_b, bus.calc_op, bus.calc_ms},
                    {sb[0].a, sb[0].b, sb[0].op, sb[0].ms});
      end
    end
    checkOutput("gntTimeout", found, 1'b1);
  endtask

  task automatic waitDone(input int gCyc, output int dCyc);
    logic found;
    txn_t t;
    found = 1'b0;
    dCyc  = -1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) begin
        found = 1'b1;
        dCyc  = cyc;
        t = sb.pop_front();
        checkOutput("doneId", {bus.done1, bus.done0}, (t.id == 1) ? 2'b10 : 2'b01);
        checkOutput("latency", dCyc - gCyc, CALC_LAT + 1);
        if (t.id == 1) begin
          checkOutput("res1", bus.res1, t.res);
          checkOutput("res0Untouched", bus.res0, lastRes0);
          lastRes1 = t.res;
        end else begin
          checkOutput("res0", bus.res0, t.res);
          checkOutput("res1Untouched", bus.res1, lastRes1);
          lastRes0 = t.res;
        end
      end else begin
        checkOutput("waitHold",
                    {bus.gnt0, bus.gnt1, bus.calc_equal, bus.busy,
                     bus.calc_a, bus.calc_b, bus.calc_op, bus.calc_ms},
                    {4'b0001, sb[0].a, sb[0].b, sb[0].op, sb[0].ms});
      end
    end
    checkOutput("doneTimeout", found, 1'b1);
  endtask

  initial begin
    int g;
    int d;
    int prevG;
    logic [DW+DW+OPW:0] held;

    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.op0 = '0; bus.ms0 = 1'b0;
    bus.a1 = '0; bus.b1 = '0; bus.op1 = '0; bus.ms1 = 1'b0;
    lastRes0 = '0;
    lastRes1 = '0;
    repeat (2) @(negedge clk);
    checkOutput("resetState",
                {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.calc_equal,
                 bus.res0, bus.res1, bus.calc_a, bus.calc_b, bus.calc_op, bus.calc_ms}, 0);
    reset = 1'b0;

    $display("[TB] single requester 0");
    applyStimulus(0, 3'd3, 3'd1, 3'b000, 1'b1);
    waitGrant(g);
    waitDone(g, d);
    bus.req0 = 1'b0;

    $display("[TB] simultaneous requests after reset");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    lastRes0 = '0;
    lastRes1 = '0;
    applyStimulus(0, 3'd2, 3'd5, 3'b000, 1'b0);
    applyStimulus(1, 3'd3, 3'd2, 3'b001, 1'b1);
    waitGrant(g);
    waitDone(g, d);
    bus.req0 = 1'b0;
    prevG = d;
    waitGrant(g);
    checkOutput("rrGapAfterDone", g - prevG, 2);
    waitDone(g, d);
    bus.req1 = 1'b0;

    $display("[TB] both requests held for four transactions");
    applyStimulus(0, 3'd1, 3'd2, 3'b000, 1'b0);
    applyStimulus(1, 3'd2, 3'd3, 3'b001, 1'b1);
    prevG = -1;
    for (int k = 0; k < 4; k++) begin
      waitGrant(g);
      if (k > 0) checkOutput("issuePeriod", g - prevG, CALC_LAT + 3);
      prevG = g;
      waitDone(g, d);
      if (k == 0) applyStimulus(0, 3'd6, 3'd5, 3'b001, 1'b1);
      if (k == 1) applyStimulus(1, 3'd7, 3'd4, 3'b000, 1'b0);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    $display("[TB] one-cycle request pulse on requester 1");
    @(negedge clk);
    applyStimulus(1, 3'd7, 3'd7, 3'b000, 1'b0);
    waitGrant(g);
    bus.req1 = 1'b0;
    bus.a1 = 3'd0;
    bus.b1 = 3'd1;
    waitDone(g, d);

    $display("[TB] reset during WAIT");
    @(negedge clk);
    applyStimulus(0, 3'd5, 3'd2, 3'b000, 1'b1);
    waitGrant(g);
    @(negedge clk);
    reset = 1'b1;
    bus.req0 = 1'b0;
    @(negedge clk);
    checkOutput("resetMidTxn",
                {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.calc_equal,
                 bus.res0, bus.res1, bus.calc_a, bus.calc_b, bus.calc_op, bus.calc_ms}, 0);
    reset = 1'b0;
    sb.delete();
    lastRes0 = '0;
    lastRes1 = '0;
    applyStimulus(0, 3'd2, 3'd2, 3'b001, 1'b0);
    waitGrant(g);
    waitDone(g, d);
    bus.req0 = 1'b0;

    $display("[TB] idle for 20 cycles");
    @(negedge clk);
    held = {bus.calc_a, bus.calc_b, bus.calc_op, bus.calc_ms};
    checkOutput("idleHeldOperands", held, {3'd2, 3'd2, 3'b001, 1'b0});
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("idleQuiet",
                  {bus.busy, bus.calc_equal, bus.calc_a, bus.calc_b, bus.calc_op, bus.calc_ms},
                  {2'b00, held});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
